// File: rtl/lsu_mem_ctrl.sv
// Load/store unit between EXU and WBU: one memory request per op, load extract/extend, store lane shift and strobes.
// Latency: 3 cycles accept-to-result when memory answers at once; 1 cycle for none ops and size/alignment faults.
// Backpressure: accepts only when idle; the request is held until req_ready_i and the result is held until out_ready_i.
module lsu_mem_ctrl #(
    parameter int XLEN   = 32,
    parameter int ADDR_W = 32,
    parameter int PASS_W = 87
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [1:0]        in_op_i,
    input  logic [1:0]        in_size_i,
    input  logic              in_signed_i,
    input  logic [ADDR_W-1:0] in_addr_i,
    input  logic [XLEN-1:0]   in_wdata_i,
    input  logic [PASS_W-1:0] in_pass_i,
    output logic              req_valid_o,
    input  logic              req_ready_i,
    output logic              req_we_o,
    output logic [ADDR_W-1:0] req_addr_o,
    output logic [XLEN-1:0]   req_wdata_o,
    output logic [XLEN/8-1:0] req_wstrb_o,
    input  logic              resp_valid_i,
    input  logic [XLEN-1:0]   resp_rdata_i,
    input  logic              resp_err_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [XLEN-1:0]   out_rdata_o,
    output logic [PASS_W-1:0] out_pass_o,
    output logic              out_excp_o,
    output logic [3:0]        out_excp_code_o
);
    localparam int NB    = XLEN / 8;
    localparam int OFF_W = $clog2(NB);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

    state_t              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [1:0]          size_q, size_d;
    logic                signed_q, signed_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [XLEN-1:0]     wdata_q, wdata_d;
    logic [PASS_W-1:0]   pass_q, pass_d;
    logic [XLEN-1:0]     rdata_q, rdata_d;
    logic                excp_q, excp_d;
    logic [3:0]          code_q, code_d;

    logic [OFF_W-1:0]    off;
    logic [XLEN-1:0]     shifted;
    logic [XLEN-1:0]     keep;
    logic [XLEN-1:0]     load_val;
    logic                sign_bit;
    logic [NB-1:0]       strb_base;
    logic                in_load;
    logic                in_store;
    logic                in_bad;

    // Byte lane of the access inside the data word
    assign off = addr_q[OFF_W-1:0];

    assign in_ready_o      = (state_q == S_IDLE);
    assign req_valid_o     = (state_q == S_REQ);
    assign req_we_o        = is_store_q;
    assign req_addr_o      = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    assign out_valid_o     = (state_q == S_DONE);
    assign out_rdata_o     = rdata_q;
    assign out_pass_o      = pass_q;
    assign out_excp_o      = excp_q;
    assign out_excp_code_o = code_q;

    // Incoming op decode: dword is illegal on a 32-bit datapath, other sizes must be naturally aligned
    always_comb begin
        in_load  = (in_op_i == 2'b01);
        in_store = (in_op_i == 2'b10);
        in_bad   = 1'b0;
        case (in_size_i)
            2'b01:   in_bad = in_addr_i[0];
            2'b10:   in_bad = |in_addr_i[1:0];
            2'b11:   in_bad = (XLEN == 32) || (|in_addr_i[2:0]);
            default: in_bad = 1'b0;
        endcase
    end

    // Load path: bring the addressed lane down to bit 0, then zero- or sign-extend by access size
    always_comb begin
        shifted  = resp_rdata_i >> {off, 3'b000};
        keep     = '1;
        sign_bit = 1'b0;
        case (size_q)
            2'b00:   begin keep = XLEN'(8'hFF);         sign_bit = shifted[7];  end
            2'b01:   begin keep = XLEN'(16'hFFFF);      sign_bit = shifted[15]; end
            2'b10:   begin keep = XLEN'(32'hFFFF_FFFF); sign_bit = shifted[31]; end
            default: begin keep = '1;                   sign_bit = 1'b0;        end
        endcase
        load_val = (shifted & keep) | ((signed_q && sign_bit) ? ~keep : '0);
    end

    // Store path: move right-aligned data and its strobe pattern up to the addressed lane
    always_comb begin
        case (size_q)
            2'b00:   strb_base = NB'(8'h01);
            2'b01:   strb_base = NB'(8'h03);
            2'b10:   strb_base = NB'(8'h0F);
            default: strb_base = '1;
        endcase
        req_wstrb_o = is_store_q ? (strb_base << off) : '0;
        req_wdata_o = wdata_q << {off, 3'b000};
    end

    // Next state and result capture; op fields are only latched on the input handshake
    always_comb begin
        state_d    = state_q;
        is_store_d = is_store_q;
        size_d     = size_q;
        signed_d   = signed_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        pass_d     = pass_q;
        rdata_d    = rdata_q;
        excp_d     = excp_q;
        code_d     = code_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid_i) begin
                    is_store_d = in_store;
                    size_d     = in_size_i;
                    signed_d   = in_signed_i;
                    addr_d     = in_addr_i;
                    wdata_d    = in_wdata_i;
                    pass_d     = in_pass_i;
                    rdata_d    = '0;
                    excp_d     = 1'b0;
                    code_d     = 4'd0;
                    if (!(in_load || in_store)) begin
                        state_d = S_DONE;
                    end else if (in_bad) begin
                        excp_d  = 1'b1;
                        code_d  = in_store ? 4'd6 : 4'd4;
                        state_d = S_DONE;
                    end else begin
                        state_d = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (req_ready_i) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (resp_valid_i) begin
                    state_d = S_DONE;
                    if (resp_err_i) begin
                        excp_d  = 1'b1;
                        code_d  = is_store_q ? 4'd7 : 4'd5;
                        rdata_d = '0;
                    end else begin
                        rdata_d = is_store_q ? '0 : load_val;
                    end
                end
            end
            S_DONE: begin
                if (out_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and captured-op registers; reset abandons any transaction in flight
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            is_store_q <= 1'b0;
            size_q     <= 2'b00;
            signed_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            pass_q     <= '0;
            rdata_q    <= '0;
            excp_q     <= 1'b0;
            code_q     <= 4'd0;
        end else begin
            state_q    <= state_d;
            is_store_q <= is_store_d;
            size_q     <= size_d;
            signed_q   <= signed_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            pass_q     <= pass_d;
            rdata_q    <= rdata_d;
            excp_q     <= excp_d;
            code_q     <= code_d;
        end
    end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// Bench for lsu_mem_ctrl: a 32-bit and a 64-bit instance share one stimulus set selected by sel.
// Expected results come from a transaction-level model of the load/store rules.
// Directed cases pin literal values; randomized ops with random stalls cover the rest.
module tb_lsu_mem_ctrl;
    localparam int AW = 32;
    localparam int PW = 87;
    localparam int PH_IDLE = 0;
    localparam int PH_REQ  = 1;
    localparam int PH_WAIT = 2;
    localparam int PH_DONE = 3;

    typedef struct packed {
        logic          has_req;
        logic          we;
        logic [AW-1:0] addr;
        logic [63:0]   wdata;
        logic [7:0]    strb;
        logic [63:0]   rdata;
        logic          excp;
        logic [3:0]    code;
        logic [PW-1:0] pass;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n = 1'b0;
    logic          sel = 1'b0;
    logic          in_valid = 1'b0;
    logic [1:0]    in_op = '0;
    logic [1:0]    in_size = '0;
    logic          in_signed = 1'b0;
    logic [AW-1:0] in_addr = '0;
    logic [63:0]   in_wdata = '0;
    logic [PW-1:0] in_pass = '0;
    logic          req_ready = 1'b0;
    logic          resp_valid = 1'b0;
    logic [63:0]   resp_rdata = '0;
    logic          resp_err = 1'b0;
    logic          out_ready = 1'b0;

    logic          in_ready_a, req_valid_a, req_we_a, out_valid_a, out_excp_a;
    logic [AW-1:0] req_addr_a;
    logic [31:0]   req_wdata_a, out_rdata_a;
    logic [3:0]    req_wstrb_a, out_code_a;
    logic [PW-1:0] out_pass_a;
    logic          in_ready_b, req_valid_b, req_we_b, out_valid_b, out_excp_b;
    logic [AW-1:0] req_addr_b;
    logic [63:0]   req_wdata_b, out_rdata_b;
    logic [7:0]    req_wstrb_b;
    logic [3:0]    out_code_b;
    logic [PW-1:0] out_pass_b;

    logic          in_ready, req_valid, req_we, out_valid, out_excp;
    logic [AW-1:0] req_addr;
    logic [63:0]   req_wdata, out_rdata;
    logic [7:0]    req_wstrb;
    logic [3:0]    out_code;
    logic [PW-1:0] out_pass;

    assign in_ready  = sel ? in_ready_b  : in_ready_a;
    assign req_valid = sel ? req_valid_b : req_valid_a;
    assign req_we    = sel ? req_we_b    : req_we_a;
    assign req_addr  = sel ? req_addr_b  : req_addr_a;
    assign req_wdata = sel ? req_wdata_b : {32'h0, req_wdata_a};
    assign req_wstrb = sel ? req_wstrb_b : {4'h0, req_wstrb_a};
    assign out_valid = sel ? out_valid_b : out_valid_a;
    assign out_rdata = sel ? out_rdata_b : {32'h0, out_rdata_a};
    assign out_excp  = sel ? out_excp_b  : out_excp_a;
    assign out_code  = sel ? out_code_b  : out_code_a;
    assign out_pass  = sel ? out_pass_b  : out_pass_a;

    lsu_mem_ctrl #(.XLEN(32), .ADDR_W(AW), .PASS_W(PW)) dut32 (
        .clk_i(clk), .rst_i(rst_n),
        .in_valid_i(in_valid & ~sel), .in_ready_o(in_ready_a),
        .in_op_i(in_op), .in_size_i(in_size), .in_signed_i(in_signed),
        .in_addr_i(in_addr), .in_wdata_i(in_wdata[31:0]), .in_pass_i(in_pass),
        .req_valid_o(req_valid_a), .req_ready_i(req_ready & ~sel), .req_we_o(req_we_a),
        .req_addr_o(req_addr_a), .req_wdata_o(req_wdata_a), .req_wstrb_o(req_wstrb_a),
        .resp_valid_i(resp_valid & ~sel), .resp_rdata_i(resp_rdata[31:0]), .resp_err_i(resp_err),
        .out_valid_o(out_valid_a), .out_ready_i(out_ready & ~sel), .out_rdata_o(out_rdata_a),
        .out_pass_o(out_pass_a), .out_excp_o(out_excp_a), .out_excp_code_o(out_code_a)
    );

    lsu_mem_ctrl #(.XLEN(64), .ADDR_W(AW), .PASS_W(PW)) dut64 (
        .clk_i(clk), .rst_i(rst_n),
        .in_valid_i(in_valid & sel), .in_ready_o(in_ready_b),
        .in_op_i(in_op), .in_size_i(in_size), .in_signed_i(in_signed),
        .in_addr_i(in_addr), .in_wdata_i(in_wdata), .in_pass_i(in_pass),
        .req_valid_o(req_valid_b), .req_ready_i(req_ready & sel), .req_we_o(req_we_b),
        .req_addr_o(req_addr_b), .req_wdata_o(req_wdata_b), .req_wstrb_o(req_wstrb_b),
        .resp_valid_i(resp_valid & sel), .resp_rdata_i(resp_rdata), .resp_err_i(resp_err),
        .out_valid_o(out_valid_b), .out_ready_i(out_ready & sel), .out_rdata_o(out_rdata_b),
        .out_pass_o(out_pass_b), .out_excp_o(out_excp_b), .out_excp_code_o(out_code_b)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    int   phase = PH_IDLE;
    exp_t exp_cur = '0;

    int            ncnt = 0;
    int            acc_n = 0;
    int            lat = 0;
    bit            seen_out = 1'b0;
    bit            saw_req = 1'b0;
    logic [AW-1:0] last_req_addr = '0;
    logic [63:0]   last_req_wdata = '0;
    logic [7:0]    last_req_wstrb = '0;
    logic          last_req_we = 1'b0;
    logic [63:0]   last_rdata = '0;
    logic          last_excp = 1'b0;
    logic [3:0]    last_code = '0;

    function automatic void chk(string name, logic [127:0] act, logic [127:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    endfunction

    // What one op must produce, straight from the load/store rules
    function automatic exp_t model(int xlen, logic [1:0] op, logic [1:0] size, logic sgn,
                                   logic [AW-1:0] addr, logic [63:0] wdata, logic [PW-1:0] pass,
                                   logic [63:0] rdata, logic err);
        exp_t         e;
        int           nb;
        int           off;
        int           bytes;
        logic [127:0] xmask;
        logic [127:0] fmask;
        logic [127:0] v;
        e     = '0;
        e.pass = pass;
        nb    = xlen / 8;
        off   = int'(addr[2:0]) % nb;
        bytes = 1 << size;
        xmask = (128'd1 << xlen) - 128'd1;
        fmask = (128'd1 << (8 * bytes)) - 128'd1;
        if (op == 2'b01 || op == 2'b10) begin
            if (bytes > nb || (int'(addr[2:0]) % bytes) != 0) begin
                e.excp = 1'b1;
                e.code = (op == 2'b01) ? 4'd4 : 4'd6;
            end else begin
                e.has_req = 1'b1;
                e.we      = (op == 2'b10);
                e.addr    = addr - AW'(off);
                if (op == 2'b10) begin
                    e.wdata = 64'(((128'(wdata) & xmask) << (8 * off)) & xmask);
                    e.strb  = 8'(((1 << bytes) - 1) << off);
                end
                if (err) begin
                    e.excp = 1'b1;
                    e.code = (op == 2'b01) ? 4'd5 : 4'd7;
                end else if (op == 2'b01) begin
                    v = ((128'(rdata) & xmask) >> (8 * off)) & fmask;
                    if (sgn && v[8 * bytes - 1]) v = v | ~fmask;
                    e.rdata = 64'(v & xmask);
                end
            end
        end
        return e;
    endfunction

    // Per-cycle compare of handshake signals and held fields against the model
    always @(negedge clk) begin
        if (rst_n) begin
            ncnt++;
            if (in_valid && in_ready) begin
                acc_n    = ncnt;
                seen_out = 1'b0;
                saw_req  = 1'b0;
            end
            chk("in_ready", in_ready, phase == PH_IDLE);
            chk("req_valid", req_valid, phase == PH_REQ);
            chk("out_valid", out_valid, phase == PH_DONE);
            if (req_valid) begin
                saw_req        = 1'b1;
                last_req_addr  = req_addr;
                last_req_wdata = req_wdata;
                last_req_wstrb = req_wstrb;
                last_req_we    = req_we;
                chk("req_we", req_we, exp_cur.we);
                chk("req_addr", req_addr, exp_cur.addr);
                chk("req_wstrb", req_wstrb, exp_cur.strb);
                if (exp_cur.we) chk("req_wdata", req_wdata, exp_cur.wdata);
            end
            if (out_valid) begin
                if (!seen_out) begin
                    seen_out = 1'b1;
                    lat      = ncnt - acc_n;
                end
                last_rdata = out_rdata;
                last_excp  = out_excp;
                last_code  = out_code;
                chk("out_rdata", out_rdata, exp_cur.rdata);
                chk("out_excp", out_excp, exp_cur.excp);
                chk("out_code", out_code, exp_cur.code);
                chk("out_pass", out_pass, exp_cur.pass);
            end
        end
    end

    task automatic start_op(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                            input logic [AW-1:0] addr, input logic [63:0] wdata,
                            input logic [63:0] rdata, input logic err, output bit ok);
        logic [PW-1:0] pass;
        pass    = PW'({$urandom(), $urandom(), $urandom()});
        exp_cur = model(sel ? 64 : 32, op, size, sgn, addr, wdata, pass, rdata, err);
        in_op = op; in_size = size; in_signed = sgn; in_addr = addr; in_wdata = wdata; in_pass = pass;
        in_valid = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            chk("accept_timeout", in_ready, 1'b1);
            in_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        in_valid  = 1'b0;
        in_op     = 2'($urandom());
        in_size   = 2'($urandom());
        in_addr   = $urandom();
        in_wdata  = {$urandom(), $urandom()};
        in_pass   = PW'({$urandom(), $urandom(), $urandom()});
        phase     = exp_cur.has_req ? PH_REQ : PH_DONE;
    endtask

    task automatic do_req(input int k, input bit glitch);
        req_ready = 1'b0;
        repeat (k) begin @(posedge clk); #1; end
        req_ready = 1'b1;
        if (glitch) begin
            resp_valid = 1'b1;
            resp_rdata = {$urandom(), $urandom()};
            resp_err   = 1'($urandom());
        end
        @(posedge clk); #1;
        req_ready  = 1'b0;
        resp_valid = 1'b0;
        phase      = PH_WAIT;
    endtask

    task automatic do_resp(input int k, input logic [63:0] rdata, input logic err);
        resp_valid = 1'b0;
        repeat (k) begin @(posedge clk); #1; end
        resp_valid = 1'b1;
        resp_rdata = rdata;
        resp_err   = err;
        @(posedge clk); #1;
        resp_valid = 1'b0;
        resp_rdata = {$urandom(), $urandom()};
        resp_err   = 1'b0;
        phase      = PH_DONE;
    endtask

    task automatic do_out(input int k);
        out_ready = 1'b0;
        repeat (k) begin @(posedge clk); #1; end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        phase     = PH_IDLE;
    endtask

    task automatic do_op(input logic [1:0] op, input logic [1:0] size, input logic sgn,
                         input logic [AW-1:0] addr, input logic [63:0] wdata,
                         input logic [63:0] rdata, input logic err,
                         input int kq, input int ks, input int ko, input bit glitch);
        bit ok;
        start_op(op, size, sgn, addr, wdata, rdata, err, ok);
        if (!ok) return;
        if (exp_cur.has_req) begin
            do_req(kq, glitch);
            do_resp(ks, rdata, err);
        end
        do_out(ko);
        chk("latency", lat, exp_cur.has_req ? 3 + kq + ks : 1);
    endtask

    // Idle cycles with stray responses that must not produce a result
    task automatic idle_gap(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            resp_valid = 1'($urandom());
            resp_rdata = {$urandom(), $urandom()};
            resp_err   = 1'($urandom());
        end
        @(posedge clk); #1;
        resp_valid = 1'b0;
    endtask

    task automatic rand_op();
        int            r;
        logic [1:0]    op;
        logic [1:0]    size;
        logic [AW-1:0] addr;
        r    = $urandom_range(0, 9);
        op   = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r < 6) ? 2'b01 : 2'b10;
        size = 2'($urandom_range(0, 3));
        addr = $urandom();
        if ($urandom_range(0, 3) != 0) addr = addr & ~AW'((1 << size) - 1);
        do_op(op, size, 1'($urandom()), addr, {$urandom(), $urandom()}, {$urandom(), $urandom()},
              ($urandom_range(0, 7) == 0),
              ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4),
              ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 4),
              ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3),
              1'($urandom()));
        idle_gap($urandom_range(0, 2));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit ok;
        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req_valid", req_valid, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_out_rdata", out_rdata, 64'h0);
        chk("rst_out_excp", out_excp, 1'b0);
        chk("rst_req_wstrb", req_wstrb, 8'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        idle_gap(2);

        // Signed byte load, memory answering at once
        do_op(2'b01, 2'b00, 1'b1, 32'h8000_0003, 64'h0, 64'h80AA_BBCC, 1'b0, 0, 0, 0, 1'b0);
        chk("lb_req_addr", last_req_addr, 32'h8000_0000);
        chk("lb_rdata", last_rdata, 64'hFFFF_FF80);
        chk("lb_latency", lat, 3);

        // Half store to the upper lane
        do_op(2'b10, 2'b01, 1'b0, 32'h0000_0102, 64'h0000_1234, 64'h0, 1'b0, 0, 0, 0, 1'b0);
        chk("sh_wdata_hi", last_req_wdata[31:16], 16'h1234);
        chk("sh_wstrb", last_req_wstrb, 8'h0C);
        chk("sh_we", last_req_we, 1'b1);
        chk("sh_rdata", last_rdata, 64'h0);
        chk("sh_excp", last_excp, 1'b0);

        // Misalignment and illegal size never reach memory
        do_op(2'b01, 2'b10, 1'b0, 32'h0000_0101, 64'h0, 64'h0, 1'b0, 0, 0, 0, 1'b0);
        chk("lw_mis_noreq", saw_req, 1'b0);
        chk("lw_mis_excp", last_excp, 1'b1);
        chk("lw_mis_code", last_code, 4'd4);
        do_op(2'b10, 2'b10, 1'b0, 32'h0000_0106, 64'h55, 64'h0, 1'b0, 0, 0, 0, 1'b0);
        chk("sw_mis_code", last_code, 4'd6);
        do_op(2'b01, 2'b11, 1'b0, 32'h0000_0100, 64'h0, 64'h0, 1'b0, 0, 0, 0, 1'b0);
        chk("ld32_code", last_code, 4'd4);
        chk("ld32_noreq", saw_req, 1'b0);

        // Backpressure on every channel
        do_op(2'b01, 2'b10, 1'b0, 32'h0000_0200, 64'h0, 64'h1122_3344, 1'b0, 5, 4, 3, 1'b1);
        chk("bp_latency", lat, 12);
        chk("bp_rdata", last_rdata, 64'h1122_3344);

        // Access fault on a load
        do_op(2'b01, 2'b10, 1'b1, 32'h0000_0300, 64'h0, 64'hFFFF_FFFF, 1'b1, 0, 1, 0, 1'b0);
        chk("lerr_excp", last_excp, 1'b1);
        chk("lerr_code", last_code, 4'd5);
        chk("lerr_rdata", last_rdata, 64'h0);
        idle_gap(4);

        // Reset while waiting for the response, then a stray late response
        start_op(2'b01, 2'b10, 1'b0, 32'h0000_0400, 64'h0, 64'h0, 1'b0, ok);
        if (ok) begin
            do_req(0, 1'b0);
            @(posedge clk); #1;
            rst_n = 1'b0;
            phase = PH_IDLE;
            @(negedge clk);
            chk("mid_rst_req_valid", req_valid, 1'b0);
            chk("mid_rst_out_valid", out_valid, 1'b0);
            chk("mid_rst_req_addr", req_addr, 32'h0);
            chk("mid_rst_out_pass", out_pass, 87'h0);
            @(posedge clk); #1;
            rst_n = 1'b1;
            @(posedge clk); #1;
            resp_valid = 1'b1;
            resp_rdata = 64'hABCD_EF01;
            @(posedge clk); #1;
            resp_valid = 1'b0;
            repeat (3) begin @(posedge clk); #1; end
        end
        do_op(2'b01, 2'b01, 1'b1, 32'h0000_0402, 64'h0, 64'h8001_0000, 1'b0, 0, 0, 0, 1'b0);
        chk("post_rst_rdata", last_rdata, 64'hFFFF_8001);

        repeat (250) rand_op();

        // 64-bit datapath
        sel = 1'b1;
        idle_gap(2);
        do_op(2'b01, 2'b10, 1'b0, 32'h0000_0104, 64'h0, 64'hDEAD_BEEF_0000_0001, 1'b0, 0, 0, 0, 1'b0);
        chk("lwu64_rdata", last_rdata, 64'h0000_0000_DEAD_BEEF);
        do_op(2'b10, 2'b00, 1'b0, 32'h0000_0007, 64'hA5, 64'h0, 1'b0, 0, 0, 0, 1'b0);
        chk("sb64_wstrb", last_req_wstrb, 8'h80);
        chk("sb64_wdata", last_req_wdata, 64'hA500_0000_0000_0000);
        do_op(2'b01, 2'b11, 1'b1, 32'h0000_0108, 64'h0, 64'h8000_0000_0000_0002, 1'b0, 0, 0, 0, 1'b0);
        chk("ld64_rdata", last_rdata, 64'h8000_0000_0000_0002);

        repeat (250) rand_op();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
